exu_muldiv_ctrl: RTL and testbench

Multi-cycle sequencer for the M-extension unit. It sits behind the dispatch stage, which provides req, operands and a one-hot op. It runs a pipelined multiplier and an iterative radix-2 restoring divider, and holds the pipeline via busy_o. The result is presented to the write-back arbiter over a valid/ready handshake.

---
 rtl/exu_muldiv_ctrl_pkg.sv | 49 ++++
 rtl/exu_muldiv_ctrl_if.sv | 27 ++
 rtl/exu_div_iter.sv | 65 ++++++
 rtl/exu_muldiv_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_exu_muldiv_ctrl.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/exu_muldiv_ctrl_pkg.sv
// Shared definitions for the M-extension multiply/divide sequencer.
// Contents: one-hot op bit indices, 2-bit FSM state encoding, divider
// iteration count and counter width, special-case result constants,
// the multiplier pipeline stage record and the op decoder.
package exu_muldiv_ctrl_pkg;

    // Bit positions inside the one-hot op vector
    localparam int OP_MUL    = 0;
    localparam int OP_MULH   = 1;
    localparam int OP_MULHSU = 2;
    localparam int OP_MULHU  = 3;
    localparam int OP_DIV    = 4;
    localparam int OP_DIVU   = 5;
    localparam int OP_REM    = 6;
    localparam int OP_REMU   = 7;

    // FSM state encoding
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int DIV_ITER_DEF = 32;
    localparam int CNT_W        = 5;

    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN  = 32'h8000_0000;

    // One multiplier pipeline stage. Only the low 64 bits of the 66-bit
    // signed product ever reach a result, so the top two are not carried.
    typedef struct packed {
        logic        hi;
        logic [63:0] prod;
    } mul_stage_t;

    // Normalises the dispatch op: bit0 wins over anything else, otherwise a
    // clean one-hot passes through; zero or multi-hot without bit0 -> 0 (drop).
    function automatic logic [7:0] op_decode(input logic [7:0] op);
        logic [7:0] r;
        r = 8'd0;
        if (op[OP_MUL]) begin
            r[OP_MUL] = 1'b1;
        end else if ((op != 8'd0) && ((op & (op - 8'd1)) == 8'd0)) begin
            r = op;
        end
        return r;
    endfunction

endpackage

// File: rtl/exu_muldiv_ctrl_if.sv
// Dispatch / write-back bus of the muldiv sequencer.
// master: dispatch + write-back arbiter side (drives req, operands, op, rd,
//         flush, wb_ready_i; observes busy and the result).
// slave : the muldiv unit.
interface exu_muldiv_ctrl_if;
    logic        req_i;
    logic [31:0] op1_i;
    logic [31:0] op2_i;
    logic [7:0]  op_i;
    logic [4:0]  rd_addr_i;
    logic        flush_i;
    logic        busy_o;
    logic        wb_valid_o;
    logic        wb_ready_i;
    logic [31:0] wb_data_o;
    logic [4:0]  wb_rd_o;

    modport master (
        output req_i, op1_i, op2_i, op_i, rd_addr_i, flush_i, wb_ready_i,
        input  busy_o, wb_valid_o, wb_data_o, wb_rd_o
    );

    modport slave (
        input  req_i, op1_i, op2_i, op_i, rd_addr_i, flush_i, wb_ready_i,
        output busy_o, wb_valid_o, wb_data_o, wb_rd_o
    );
endinterface

// File: rtl/exu_div_iter.sv
// Radix-2 restoring divider datapath for unsigned magnitudes.
// Ports: clk, rst (sync, active-high); start loads dividend/divisor and
// clears the counter; step performs one subtract-shift; clear (flush)
// resets the counter; done pulses on the step at the terminal count;
// quot/rem are the post-step values, meaningful when done is high.
module exu_div_iter
    import exu_muldiv_ctrl_pkg::*;
#(
    parameter int DIV_ITER = DIV_ITER_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        step,
    input  logic        clear,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        done,
    output logic [31:0] quot,
    output logic [31:0] rem
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITER - 1);

    logic [31:0]      quot_q;
    logic [31:0]      rem_q;
    logic [31:0]      dvsr_q;
    logic [CNT_W-1:0] cnt;
    logic [32:0]      shifted;
    logic [32:0]      diff;

    // Quotient register starts as the dividend; its MSB shifts into the
    // partial remainder while quotient bits shift in at the bottom.
    always_comb begin
        shifted = {rem_q, quot_q[31]};
        diff    = shifted - {1'b0, dvsr_q};
        if (diff[32]) begin
            rem  = shifted[31:0];
            quot = {quot_q[30:0], 1'b0};
        end else begin
            rem  = diff[31:0];
            quot = {quot_q[30:0], 1'b1};
        end
        done = step && (cnt == CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst || clear || start) begin
            cnt <= '0;
        end else if (step && (cnt != CNT_LAST)) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            quot_q <= dividend;
            rem_q  <= 32'd0;
            dvsr_q <= divisor;
        end else if (step) begin
            quot_q <= quot;
            rem_q  <= rem;
        end
    end

endmodule

// File: rtl/exu_muldiv_ctrl.sv
// Multi-cycle sequencer for the M-extension unit: pipelined multiplier,
// iterative divider and a valid/ready write-back port.
// Ports: clk, rst (sync, active-high), bus (slave modport): req/op/operands/
// rd from dispatch, flush, busy back to dispatch, wb_valid/wb_data/wb_rd to
// the write-back arbiter with wb_ready back.
module exu_muldiv_ctrl
    import exu_muldiv_ctrl_pkg::*;
#(
    parameter int MUL_STAGES = 2,
    parameter int DIV_ITER   = DIV_ITER_DEF
) (
    input  logic             clk,
    input  logic             rst,
    exu_muldiv_ctrl_if.slave bus
);
    localparam int TAP = (MUL_STAGES > 1) ? MUL_STAGES - 2 : 0;

    function automatic logic [31:0] fix_sign(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

    logic [1:0]  state;
    logic        busy;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;

    logic [7:0]  op_dec;
    logic        accept, is_mul, is_div, div_signed, is_rem;
    logic        div0, div_ovf;
    logic [31:0] special_data, div_a_abs, div_b_abs;
    logic [32:0] mul_a, mul_b;
    logic [63:0] mul_a64, mul_b64;

    mul_stage_t  mul_in, mul_tap;
    mul_stage_t  mul_pipe_p [3];
    logic [2:0]  mul_vld_p;
    logic        mul_tap_vld;
    logic [31:0] mul_result;

    logic [4:0]  rd_q;
    logic        neg_q, neg_r, rem_sel;
    logic        div_start, div_step, div_done;
    logic [31:0] div_quot, div_rem, div_result;

    always_comb begin
        op_dec     = op_decode(bus.op_i);
        is_mul     = |op_dec[3:0];
        is_div     = |op_dec[7:4];
        div_signed = op_dec[OP_DIV] | op_dec[OP_REM];
        is_rem     = op_dec[OP_REM] | op_dec[OP_REMU];
        accept     = bus.req_i & (state == S_IDLE) & ~bus.flush_i & (|op_dec);

        div0    = (bus.op2_i == 32'd0);
        div_ovf = div_signed & (bus.op1_i == INT_MIN) & (bus.op2_i == ALL_ONES);
        if (div0) begin
            special_data = is_rem ? bus.op1_i : ALL_ONES;
        end else begin
            special_data = is_rem ? 32'd0 : INT_MIN;
        end
        div_a_abs = fix_sign(bus.op1_i, div_signed & bus.op1_i[31]);
        div_b_abs = fix_sign(bus.op2_i, div_signed & bus.op2_i[31]);
        div_start = accept & is_div & ~(div0 | div_ovf);
        div_step  = (state == S_DIV);

        // 33-bit operand extension; the product is formed modulo 2^64
        mul_a       = {(op_dec[OP_MUL] | op_dec[OP_MULH] | op_dec[OP_MULHSU]) & bus.op1_i[31], bus.op1_i};
        mul_b       = {(op_dec[OP_MUL] | op_dec[OP_MULH]) & bus.op2_i[31], bus.op2_i};
        mul_a64     = {{31{mul_a[32]}}, mul_a};
        mul_b64     = {{31{mul_b[32]}}, mul_b};
        mul_in.hi   = ~op_dec[OP_MUL];
        mul_in.prod = mul_a64 * mul_b64;

        // The last product stage feeds the write-back register directly
        if (MUL_STAGES == 1) begin
            mul_tap_vld = accept & is_mul;
            mul_tap     = mul_in;
        end else begin
            mul_tap_vld = mul_vld_p[TAP];
            mul_tap     = mul_pipe_p[TAP];
        end
        mul_result = mul_tap.hi ? mul_tap.prod[63:32] : mul_tap.prod[31:0];

        div_result = rem_sel ? fix_sign(div_rem, neg_r) : fix_sign(div_quot, neg_q);
    end

    // Accept stage: operands latched, product enters stage 0
    always_ff @(posedge clk) begin
        if (accept) begin
            mul_pipe_p[0] <= mul_in;
            rd_q          <= bus.rd_addr_i;
            neg_q         <= div_signed & (bus.op1_i[31] ^ bus.op2_i[31]);
            neg_r         <= div_signed & bus.op1_i[31];
            rem_sel       <= is_rem;
        end
        for (int k = 1; k < 3; k++) begin
            mul_pipe_p[k] <= mul_pipe_p[k-1];
        end
    end

    exu_div_iter #(.DIV_ITER(DIV_ITER)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .step     (div_step),
        .clear    (bus.flush_i),
        .dividend (div_a_abs),
        .divisor  (div_b_abs),
        .done     (div_done),
        .quot     (div_quot),
        .rem      (div_rem)
    );

    // Write-back stage: FSM and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            wb_valid  <= 1'b0;
            wb_data   <= 32'd0;
            wb_rd     <= 5'd0;
            mul_vld_p <= '0;
        end else if (bus.flush_i) begin
            // A handshake in this cycle still counts; either way -> IDLE
            state     <= S_IDLE;
            busy      <= 1'b0;
            wb_valid  <= 1'b0;
            mul_vld_p <= '0;
        end else begin
            mul_vld_p <= {mul_vld_p[1:0], accept & is_mul};
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        busy <= 1'b1;
                        if (is_mul) begin
                            if (mul_tap_vld) begin
                                state    <= S_DONE;
                                wb_valid <= 1'b1;
                                wb_data  <= mul_result;
                                wb_rd    <= bus.rd_addr_i;
                            end else begin
                                state <= S_MUL;
                            end
                        end else if (div0 || div_ovf) begin
                            state    <= S_DONE;
                            wb_valid <= 1'b1;
                            wb_data  <= special_data;
                            wb_rd    <= bus.rd_addr_i;
                        end else begin
                            state <= S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    if (mul_tap_vld) begin
                        state    <= S_DONE;
                        wb_valid <= 1'b1;
                        wb_data  <= mul_result;
                        wb_rd    <= rd_q;
                    end
                end
                S_DIV: begin
                    if (div_done) begin
                        state    <= S_DONE;
                        wb_valid <= 1'b1;
                        wb_data  <= div_result;
                        wb_rd    <= rd_q;
                    end
                end
                default: begin
                    if (bus.wb_ready_i) begin
                        state    <= S_IDLE;
                        busy     <= 1'b0;
                        wb_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.busy_o     = busy;
    assign bus.wb_valid_o = wb_valid;
    assign bus.wb_data_o  = wb_data;
    assign bus.wb_rd_o    = wb_rd;

endmodule

// File: tb/tb_exu_muldiv_ctrl.sv
// Self-checking bench for exu_muldiv_ctrl: table of ops with expected result
// and latency, plus sequences for backpressure, flush, reset and drop cases.
module tb_exu_muldiv_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    exu_muldiv_ctrl_if bus();

    exu_muldiv_ctrl #(.MUL_STAGES(2), .DIV_ITER(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        int          lat;
    } exp_t;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    // Issue one op in the current cycle (N), follow it to its write-back.
    task automatic run_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] res, input int lat,
                          input int stall, input bit hold);
        exp_t e;
        int   cyc;
        bit   busy_ok;
        bit   stable_ok;
        bus.op_i       = op;
        bus.op1_i      = a;
        bus.op2_i      = b;
        bus.rd_addr_i  = rd;
        bus.req_i      = 1'b1;
        bus.wb_ready_i = (stall == 0);
        sb.push_back('{data: res, rd: rd, lat: lat});
        @(posedge clk); #1;
        if (!hold) bus.req_i = 1'b0;
        bus.op1_i     = $urandom;
        bus.op2_i     = $urandom;
        bus.rd_addr_i = ~rd;
        cyc     = 1;
        busy_ok = 1'b1;
        while (!bus.wb_valid_o && cyc < 100) begin
            if (!bus.busy_o) busy_ok = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        if (!bus.busy_o) busy_ok = 1'b0;
        e = sb.pop_front();
        check("latency", 32'(cyc), 32'(e.lat));
        check("wb_data", bus.wb_data_o, e.data);
        check("wb_rd", 32'(bus.wb_rd_o), 32'(e.rd));
        stable_ok = 1'b1;
        for (int k = 0; k < stall; k++) begin
            @(posedge clk); #1;
            if (!bus.wb_valid_o || bus.wb_data_o !== e.data || bus.wb_rd_o !== e.rd || !bus.busy_o)
                stable_ok = 1'b0;
        end
        if (stall > 0) check("backpressure_hold", 32'(stable_ok), 32'd1);
        bus.wb_ready_i = 1'b1;
        bus.req_i      = 1'b0;
        @(posedge clk); #1;
        check("busy_until_handshake", 32'(busy_ok), 32'd1);
        check("busy_after_hs", 32'(bus.busy_o), 32'd0);
        check("valid_after_hs", 32'(bus.wb_valid_o), 32'd0);
        if (hold) begin
            @(posedge clk); #1;
            check("no_reaccept", 32'(bus.busy_o), 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw;

        vecs.push_back('{8'h01, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 2});
        vecs.push_back('{8'h02, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2});
        vecs.push_back('{8'h08, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2});
        vecs.push_back('{8'h04, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 2});
        vecs.push_back('{8'h02, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 2});
        vecs.push_back('{8'h11, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F, 2});
        vecs.push_back('{8'h10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33});
        vecs.push_back('{8'h40, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33});
        vecs.push_back('{8'h20, 32'h0000_0055, 32'h0000_0000, 32'hFFFF_FFFF, 1});
        vecs.push_back('{8'h80, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 1});
        vecs.push_back('{8'h10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
        vecs.push_back('{8'h40, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1});
        vecs.push_back('{8'h10, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1});
        vecs.push_back('{8'h40, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 1});
        vecs.push_back('{8'h80, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 33});
        vecs.push_back('{8'h10, 32'h8000_0000, 32'h0000_0002, 32'hC000_0000, 33});
        vecs.push_back('{8'h10, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33});
        vecs.push_back('{8'h40, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 33});
        vecs.push_back('{8'h20, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33});
        vecs.push_back('{8'h80, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 33});

        rst            = 1'b1;
        bus.req_i      = 1'b0;
        bus.op_i       = 8'd0;
        bus.op1_i      = 32'd0;
        bus.op2_i      = 32'd0;
        bus.rd_addr_i  = 5'd0;
        bus.flush_i    = 1'b0;
        bus.wb_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(bus.busy_o), 32'd0);
        check("reset_valid", 32'(bus.wb_valid_o), 32'd0);
        check("reset_data", bus.wb_data_o, 32'd0);
        check("reset_rd", 32'(bus.wb_rd_o), 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1), vecs[i].exp, vecs[i].lat, 0, 1'b0);
        end

        // Backpressure with req held while busy
        run_op(8'h20, 32'd100, 32'd7, 5'd17, 32'd14, 33, 3, 1'b1);

        // Flush a divide at N+10, then a mulhu right behind it
        bus.op_i = 8'h10; bus.op1_i = 32'hFFFF_FFF9; bus.op2_i = 32'd2;
        bus.rd_addr_i = 5'd9; bus.req_i = 1'b1;
        @(posedge clk); #1;
        bus.req_i = 1'b0;
        saw = 1'b0;
        for (int k = 1; k < 10; k++) begin
            if (bus.wb_valid_o) saw = 1'b1;
            @(posedge clk); #1;
        end
        if (bus.wb_valid_o) saw = 1'b1;
        bus.flush_i = 1'b1;
        @(posedge clk); #1;
        bus.flush_i = 1'b0;
        check("flush_no_valid", 32'(saw | bus.wb_valid_o), 32'd0);
        check("flush_busy", 32'(bus.busy_o), 32'd0);
        run_op(8'h08, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 32'hFFFF_FFFE, 2, 0, 1'b0);

        // Reset during divide iteration 5
        bus.op_i = 8'h10; bus.op1_i = 32'd1000; bus.op2_i = 32'd3;
        bus.rd_addr_i = 5'd11; bus.req_i = 1'b1;
        @(posedge clk); #1;
        bus.req_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_busy", 32'(bus.busy_o), 32'd0);
        check("midrst_valid", 32'(bus.wb_valid_o), 32'd0);
        check("midrst_data", bus.wb_data_o, 32'd0);
        check("midrst_rd", 32'(bus.wb_rd_o), 32'd0);
        saw = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (bus.wb_valid_o || bus.busy_o) saw = 1'b1;
        end
        check("midrst_no_result", 32'(saw), 32'd0);

        // flush together with req in IDLE is not accepted
        bus.op_i = 8'h01; bus.op1_i = 32'd2; bus.op2_i = 32'd3;
        bus.req_i = 1'b1; bus.flush_i = 1'b1;
        @(posedge clk); #1;
        bus.req_i = 1'b0; bus.flush_i = 1'b0;
        check("flush_req_busy", 32'(bus.busy_o), 32'd0);
        saw = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.wb_valid_o) saw = 1'b1;
        end
        check("flush_req_no_valid", 32'(saw), 32'd0);

        // Multi-hot op without bit0 is dropped
        bus.op_i = 8'h06; bus.req_i = 1'b1;
        @(posedge clk); #1;
        bus.req_i = 1'b0;
        check("drop_busy", 32'(bus.busy_o), 32'd0);
        @(posedge clk); #1;
        check("drop_valid", 32'(bus.wb_valid_o), 32'd0);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
